// File: rtl/elemdiv_pkg.sv
// Shared types and width helpers for the sequential elementwise divider.
// Latency: n/a (types only).
// Backpressure: n/a.
package elemdiv_pkg;

  localparam int N_DEF     = 8;
  localparam int LANES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Dividend / quotient width.
  function automatic int dvd_w(input int n);
    return 2 * n;
  endfunction

  // Partial remainder width, including the trial-subtraction headroom bit.
  function automatic int pr_w(input int n);
    return n + 1;
  endfunction

  // Bit counter width, large enough to hold 2N.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_div_lane.sv
// Single-lane restoring shift-subtract divider: 2N-bit dividend by N-bit divisor.
// Latency: 1 load cycle + 2N step cycles; result is valid combinationally during the last step.
// Backpressure: none; the controller drives load/step and samples the result when last=1.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                capture dividend/divisor, clear partial remainder, counter=2N
//   step                perform one shift/trial-subtract iteration
//   dividend, divisor   operands sampled on load
//   last                high while the step in progress is the final one
//   quotient, remainder result as it will stand after the current step (div-by-zero overridden)
module seq_restoring_div_lane
  import elemdiv_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             last,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder
);

  localparam int DW = dvd_w(N);
  localparam int PW = pr_w(N);
  localparam int CW = cnt_w(N);

  // Committed remainder only needs N bits: after each commit it is below the
  // divisor. The N+1-bit partial remainder exists as 'shifted' below.
  logic [N-1:0]  rem_q;
  logic [DW-1:0] sr_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;

  logic [PW-1:0] shifted;
  logic          ge;
  logic [N-1:0]  diff;
  logic [N-1:0]  rem_nxt;
  logic [DW-1:0] sr_nxt;
  logic          dz;

  always_comb begin
    shifted = {rem_q, sr_q[DW-1]};
    // Non-negative trial result is the same as shifted >= divisor.
    ge      = (shifted >= {1'b0, dvs_q});
    // When ge holds (and divisor != 0) the true difference fits in N bits.
    diff    = shifted[N-1:0] - dvs_q;
    rem_nxt = ge ? diff : shifted[N-1:0];
    sr_nxt  = {sr_q[DW-2:0], ge};
    dz      = (dvs_q == '0);
    quotient  = dz ? '1 : sr_nxt;
    remainder = dz ? '0 : rem_nxt;
    last      = (cnt_q == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      sr_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      sr_q  <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(2 * N);
    end else if (step) begin
      rem_q <= rem_nxt;
      sr_q  <= sr_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/elementwise_div_seq.sv
// Sequential elementwise divider: LANES quotient/remainder pairs, one lane at a time.
// Latency: LANES*(2N+1) busy cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is sampled only in IDLE; requests while busy/done are dropped, not queued.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 run request (IDLE only)
//   dividend[LANES]       2N-bit dividends, captured on accepted start
//   divisor[LANES]        N-bit divisors, captured on accepted start
//   quotient[LANES]       2N-bit quotients (all ones on divide-by-zero)
//   remainder[LANES]      N-bit remainders (0 on divide-by-zero)
//   busy, done            busy during LOAD/DIV; done pulses for one cycle afterwards
//   cycle_count           busy cycles of the current/last run
//   dz_flags[LANES-1:0]   per-lane divide-by-zero flags, present only with ELEMDIV_DZ_FLAG_EN
module elementwise_div_seq
  import elemdiv_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   dividend    [0:LANES-1],
  input  logic [N-1:0]     divisor     [0:LANES-1],
  output logic [2*N-1:0]   quotient    [0:LANES-1],
  output logic [N-1:0]     remainder   [0:LANES-1],
  output logic             busy,
  output logic             done,
  output logic [15:0]      cycle_count
`ifdef ELEMDIV_DZ_FLAG_EN
  ,
  output logic [LANES-1:0] dz_flags
`endif
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);

  state_t state_q, state_d;
  logic [IW-1:0]  lane_idx;
  logic [2*N-1:0] cap_dividend [0:LANES-1];
  logic [N-1:0]   cap_divisor  [0:LANES-1];

  logic           accept;
  logic           lane_load;
  logic           lane_step;
  logic           lane_last;
  logic [2*N-1:0] lane_q;
  logic [N-1:0]   lane_r;
  logic           lane_store;

  seq_restoring_div_lane #(.N(N)) u_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lane_load),
    .step      (lane_step),
    .dividend  (cap_dividend[lane_idx]),
    .divisor   (cap_divisor[lane_idx]),
    .last      (lane_last),
    .quotient  (lane_q),
    .remainder (lane_r)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = DIV;
      DIV:  if (lane_last) state_d = (lane_idx == LAST_LANE) ? DONE : LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy       = (state_q == LOAD) || (state_q == DIV);
    done       = (state_q == DONE);
    accept     = (state_q == IDLE) && start;
    lane_load  = (state_q == LOAD);
    lane_step  = (state_q == DIV);
    lane_store = lane_step && lane_last;
  end

  // Operand capture, lane sequencing and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx    <= '0;
      cycle_count <= '0;
      for (int k = 0; k < LANES; k++) begin
        cap_dividend[k] <= '0;
        cap_divisor[k]  <= '0;
        quotient[k]     <= '0;
        remainder[k]    <= '0;
      end
    end else begin
      if (accept) begin
        lane_idx    <= '0;
        cycle_count <= '0;
        for (int k = 0; k < LANES; k++) begin
          cap_dividend[k] <= dividend[k];
          cap_divisor[k]  <= divisor[k];
        end
      end
      if (busy) cycle_count <= cycle_count + 16'd1;
      if (lane_store) begin
        quotient[lane_idx]  <= lane_q;
        remainder[lane_idx] <= lane_r;
        if (lane_idx != LAST_LANE) lane_idx <= lane_idx + IW'(1);
      end
    end
  end

`ifdef ELEMDIV_DZ_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_flags <= '0;
    end else if (accept) begin
      dz_flags <= '0;
    end else if (lane_store && (cap_divisor[lane_idx] == '0)) begin
      dz_flags[lane_idx] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_elementwise_div_seq.sv
// Self-checking bench for elementwise_div_seq: directed vectors plus random runs
// compared against an arithmetic reference (/, %) with lane completion every 2N+1 cycles.
module tb_elementwise_div_seq;

  localparam int N     = 8;
  localparam int LANES = 4;
  localparam int LT    = 2 * N + 1;
  localparam int LAT   = LANES * LT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend  [0:LANES-1];
  logic [N-1:0]   divisor   [0:LANES-1];
  logic [2*N-1:0] quotient  [0:LANES-1];
  logic [N-1:0]   remainder [0:LANES-1];
  logic           busy;
  logic           done;
  logic [15:0]    cycle_count;
`ifdef ELEMDIV_DZ_FLAG_EN
  logic [LANES-1:0] dz_flags;
`endif

  elementwise_div_seq #(.N(N), .LANES(LANES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
`ifdef ELEMDIV_DZ_FLAG_EN
    ,
    .dz_flags    (dz_flags)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Values the outputs should hold outside a run (previous-run results).
  logic [2*N-1:0] exp_q [0:LANES-1];
  logic [N-1:0]   exp_r [0:LANES-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic scramble();
    for (int j = 0; j < LANES; j++) begin
      dividend[j] = 16'($urandom);
      divisor[j]  = 8'($urandom);
    end
  endtask

  task automatic ref_div(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                         output logic [2*N-1:0] q, output logic [N-1:0] r);
    if (dv == 0) begin
      q = '1;
      r = '0;
    end else begin
      q = dd / dv;
      r = N'(dd % dv);
    end
  endtask

  // Called at a negedge with the DUT idle and operands already driven.
  task automatic run_check(input string tag);
    logic [2*N-1:0]   nq [0:LANES-1];
    logic [N-1:0]     nr [0:LANES-1];
    logic [LANES-1:0] ndz;
    logic             upd;
    for (int j = 0; j < LANES; j++) begin
      ref_div(dividend[j], divisor[j], nq[j], nr[j]);
      ndz[j] = (divisor[j] == 0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_at_accept"}, busy, 1);
    check({tag, ".cc_at_accept"}, cycle_count, 0);
    scramble();  // must not affect this run
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s.cc@%0d", tag, k), cycle_count, (k < LAT) ? k : LAT);
      check($sformatf("%s.done@%0d", tag, k), done, (k == LAT));
      check($sformatf("%s.busy@%0d", tag, k), busy, (k < LAT));
      for (int j = 0; j < LANES; j++) begin
        upd = (k >= LT * (j + 1));
        check($sformatf("%s.q%0d@%0d", tag, j, k), quotient[j], upd ? nq[j] : exp_q[j]);
        check($sformatf("%s.r%0d@%0d", tag, j, k), remainder[j], upd ? nr[j] : exp_r[j]);
`ifdef ELEMDIV_DZ_FLAG_EN
        check($sformatf("%s.dz%0d@%0d", tag, j, k), dz_flags[j], upd && ndz[j]);
`endif
      end
    end
    for (int j = 0; j < LANES; j++) begin
      exp_q[j] = nq[j];
      exp_r[j] = nr[j];
    end
    @(negedge clk);
  endtask

  task automatic set_basic();
    dividend[0] = 16'd6;     divisor[0] = 8'd3;
    dividend[1] = 16'd200;   divisor[1] = 8'd7;
    dividend[2] = 16'd65025; divisor[2] = 8'd255;
    dividend[3] = 16'd0;     divisor[3] = 8'd5;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".cc"}, cycle_count, 0);
    for (int j = 0; j < LANES; j++) begin
      check($sformatf("%s.q%0d", tag, j), quotient[j], 0);
      check($sformatf("%s.r%0d", tag, j), remainder[j], 0);
      exp_q[j] = '0;
      exp_r[j] = '0;
    end
`ifdef ELEMDIV_DZ_FLAG_EN
    check({tag, ".dz"}, dz_flags, 0);
`endif
  endtask

  initial begin
    int               acc [$];
    logic             prev_busy;
    logic [2*N-1:0]   sdd [0:LANES-1];
    logic [N-1:0]     sdv [0:LANES-1];
    logic [2*N-1:0]   q;
    logic [N-1:0]     r;
    bit               seen;

    scramble();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic vectors
    set_basic();
    run_check("basic");
    // Explicit constants for the basic vectors
    check("basic.q1_const", quotient[1], 28);
    check("basic.r1_const", remainder[1], 4);
    check("basic.q2_const", quotient[2], 255);

    // Boundaries
    dividend[0] = 16'hFFFF; divisor[0] = 8'd1;
    dividend[1] = 16'hFFFE; divisor[1] = 8'd255;
    dividend[2] = 16'd1;    divisor[2] = 8'd255;
    dividend[3] = 16'd255;  divisor[3] = 8'd255;
    run_check("bound");
    check("bound.q1_const", quotient[1], 256);
    check("bound.r1_const", remainder[1], 254);

    // Divide by zero on lane 2
    set_basic();
    dividend[2] = 16'd1234; divisor[2] = 8'd0;
    run_check("divzero");
    check("divzero.q2_const", quotient[2], 16'hFFFF);
    check("divzero.r2_const", remainder[2], 0);
`ifdef ELEMDIV_DZ_FLAG_EN
    check("divzero.flags", dz_flags, 4'b0100);
`endif

    // Random runs, with occasional zero and small divisors
    for (int t = 0; t < 6; t++) begin
      scramble();
      for (int j = 0; j < LANES; j++) begin
        if ($urandom_range(0, 7) == 0) divisor[j] = 8'd0;
        else if ($urandom_range(0, 3) == 0) divisor[j] = 8'($urandom_range(1, 3));
      end
      run_check($sformatf("rand%0d", t));
    end

    // start held high for 200 edges: accepts at 0, 70, 140
    scramble();
    start = 1'b1;
    prev_busy = busy;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        acc.push_back(e);
        for (int j = 0; j < LANES; j++) begin
          sdd[j] = dividend[j];
          sdv[j] = divisor[j];
        end
      end
      if (done && busy) check($sformatf("held.done_while_busy@%0d", e), 1, 0);
      prev_busy = busy;
      @(negedge clk);
      scramble();
    end
    start = 1'b0;
    check("held.accept_count", acc.size(), 3);
    for (int m = 0; m < acc.size() && m < 3; m++)
      check($sformatf("held.accept%0d", m), acc[m], LAT + 2 * m + m * LAT + m * 0 - m * LAT + m * LAT + 0 == 0 ? 0 : m * (LAT + 2));
    seen = 1'b0;
    for (int w = 0; w < 100 && !seen; w++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("held.final_done_seen", seen, 1);
    check("held.cc", cycle_count, LAT);
    for (int j = 0; j < LANES; j++) begin
      ref_div(sdd[j], sdv[j], q, r);
      check($sformatf("held.q%0d", j), quotient[j], q);
      check($sformatf("held.r%0d", j), remainder[j], r);
      exp_q[j] = q;
      exp_r[j] = r;
    end
    @(negedge clk);

    // Reset at busy cycle 30, then a fresh basic run
    set_basic();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset.idle_no_busy", busy, 0);
    set_basic();
    run_check("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
